// File: rtl/gpio_p0_irq_cond_if.sv
// Pin-side and register-side signals of the port-0 GPIO input-conditioning stage.
// The master side drives the raw pins, the edge enables and the clear strobe.
// The slave side returns the conditioned level, the pending flags and the request.
interface gpio_p0_irq_cond_if #(
    parameter int WIDTH = 16
);
    logic [WIDTH-1:0] pin_in;
    logic [WIDTH-1:0] rise_en;
    logic [WIDTH-1:0] fall_en;
    logic             clr_wr;
    logic [WIDTH-1:0] clr_mask;
    logic [WIDTH-1:0] pin_clean;
    logic [WIDTH-1:0] irq_pending;
    logic             irq;

    modport master (
        output pin_in, rise_en, fall_en, clr_wr, clr_mask,
        input  pin_clean, irq_pending, irq
    );

    modport slave (
        input  pin_in, rise_en, fall_en, clr_wr, clr_mask,
        output pin_clean, irq_pending, irq
    );
endinterface

// File: rtl/gpio_p0_irq_cond.sv
// Port-0 GPIO input conditioning and interrupt stage.
// The raw pins pass through a two-flop synchronizer and an optional debouncer.
// Enabled rising and falling edges are latched into sticky write-1-to-clear
// pending flags. The irq output is the OR of those flags.
// Optional feature macro: GPIO_IRQ_DEBOUNCE_EN. When it is defined, a
// prescaled sample debouncer sits between the synchronizer and edge detection.
// When it is undefined, pin_clean is the synchronizer output.
module gpio_p0_irq_cond #(
    parameter int WIDTH      = 16,
    parameter int DB_DIV     = 256,
    parameter int DB_SAMPLES = 3
) (
    input  logic               clk,
    input  logic               rst,
    gpio_p0_irq_cond_if.slave  bus
);

    logic [WIDTH-1:0] sync1_r;
    logic [WIDTH-1:0] sync2_r;
    logic [WIDTH-1:0] clean_s;
    logic [WIDTH-1:0] clean_d_r;
    logic [WIDTH-1:0] pend_r;
    logic [WIDTH-1:0] rise_s;
    logic [WIDTH-1:0] fall_s;
    logic [WIDTH-1:0] clr_s;
    logic [WIDTH-1:0] pend_nxt_s;

    // Two-flop synchronizer bringing the asynchronous pins into the clk domain.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1_r <= '0;
            sync2_r <= '0;
        end else begin
            sync1_r <= bus.pin_in;
            sync2_r <= sync1_r;
        end
    end

`ifdef GPIO_IRQ_DEBOUNCE_EN
    localparam int CW = (DB_DIV > 2) ? $clog2(DB_DIV) : 1;

    logic [CW-1:0]                      cnt_r;
    logic                               tick_s;
    logic [WIDTH-1:0][DB_SAMPLES-1:0]   samp_r;
    logic [WIDTH-1:0]                   clean_r;
    logic [WIDTH-1:0]                   clean_nxt_s;

    assign tick_s = (cnt_r == CW'(DB_DIV - 1));

    // Free-running prescaler. It produces one tick every DB_DIV cycles.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_r <= '0;
        end else if (tick_s) begin
            cnt_r <= '0;
        end else begin
            cnt_r <= cnt_r + CW'(1);
        end
    end

    // Per-bit sample history. It shifts in the synchronized level on each tick.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            samp_r <= '0;
        end else if (tick_s) begin
            for (int i = 0; i < WIDTH; i++) begin
                samp_r[i] <= {samp_r[i][DB_SAMPLES-2:0], sync2_r[i]};
            end
        end else begin
            samp_r <= samp_r;
        end
    end

    // Accept a new level only when every sample in the history agrees on it.
    always_comb begin
        clean_nxt_s = clean_r;
        for (int i = 0; i < WIDTH; i++) begin
            if ((&samp_r[i]) && !clean_r[i]) begin
                clean_nxt_s[i] = 1'b1;
            end else if (!(|samp_r[i]) && clean_r[i]) begin
                clean_nxt_s[i] = 1'b0;
            end else begin
                clean_nxt_s[i] = clean_r[i];
            end
        end
    end

    // Debounced level register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            clean_r <= '0;
        end else begin
            clean_r <= clean_nxt_s;
        end
    end

    assign clean_s = clean_r;
`else
    assign clean_s = sync2_r;
`endif

    // Edge history: the conditioned level one cycle ago.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            clean_d_r <= '0;
        end else begin
            clean_d_r <= clean_s;
        end
    end

    assign rise_s = clean_s & ~clean_d_r;
    assign fall_s = ~clean_s & clean_d_r;

    // Next pending value. A set is ORed in after the clear, so a coincident edge is kept.
    always_comb begin
        clr_s = '0;
        if (bus.clr_wr) begin
            clr_s = bus.clr_mask;
        end else begin
            clr_s = '0;
        end
        pend_nxt_s = (pend_r & ~clr_s) | (rise_s & bus.rise_en) | (fall_s & bus.fall_en);
    end

    // Sticky pending flags.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pend_r <= '0;
        end else begin
            pend_r <= pend_nxt_s;
        end
    end

    assign bus.pin_clean   = clean_s;
    assign bus.irq_pending = pend_r;
    assign bus.irq         = |pend_r;

endmodule

// File: tb/tb_gpio_p0_irq_cond.sv
// Directed self-checking bench for gpio_p0_irq_cond.
// Inputs change 1 ns after a rising edge. Outputs are sampled at the same point.
module tb_gpio_p0_irq_cond;

    logic clk;
    logic rst;
    int   total;
    int   bad;

    gpio_p0_irq_cond_if #(.WIDTH(16)) bus ();

    gpio_p0_irq_cond #(
        .WIDTH      (16),
        .DB_DIV     (4),
        .DB_SAMPLES (3)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // 100 MHz clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        total        = 0;
        bad          = 0;
        rst          = 1'b0;
        bus.pin_in   = 16'h0000;
        bus.rise_en  = 16'h0000;
        bus.fall_en  = 16'h0000;
        bus.clr_wr   = 1'b0;
        bus.clr_mask = 16'h0000;
        #23;
        chk("rst_clean", {16'h0000, bus.pin_clean}, 32'h0);
        chk("rst_pend",  {16'h0000, bus.irq_pending}, 32'h0);
        chk("rst_irq",   {31'h0, bus.irq}, 32'h0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        step(2);

`ifndef GPIO_IRQ_DEBOUNCE_EN
        // Basic latency: pin_clean after 2 edges, pending after 3.
        bus.rise_en = 16'h0001;
        bus.pin_in  = 16'h0001;
        step(1);
        chk("lat_clean_e1", {16'h0, bus.pin_clean}, 32'h0);
        step(1);
        chk("lat_clean_e2", {16'h0, bus.pin_clean}, 32'h0001);
        chk("lat_pend_e2",  {16'h0, bus.irq_pending}, 32'h0);
        step(1);
        chk("lat_pend_e3",  {16'h0, bus.irq_pending}, 32'h0001);
        chk("lat_irq_e3",   {31'h0, bus.irq}, 32'h1);

        // Enable removal does not clear an already-pending bit.
        bus.rise_en = 16'h0000;
        step(2);
        chk("en_off_keep", {16'h0, bus.irq_pending}, 32'h0001);

        // A clear with an empty mask does nothing.
        bus.clr_wr   = 1'b1;
        bus.clr_mask = 16'h0000;
        step(1);
        bus.clr_wr   = 1'b0;
        chk("clr_zero", {16'h0, bus.irq_pending}, 32'h0001);

        // Write-1-to-clear.
        bus.clr_wr   = 1'b1;
        bus.clr_mask = 16'h0001;
        step(1);
        bus.clr_wr   = 1'b0;
        chk("clr_pend", {16'h0, bus.irq_pending}, 32'h0);
        chk("clr_irq",  {31'h0, bus.irq}, 32'h0);

        // A falling edge on bit 0 sets pending again.
        bus.fall_en = 16'h0001;
        bus.pin_in  = 16'h0000;
        step(3);
        chk("fall_b0", {16'h0, bus.irq_pending}, 32'h0001);
        bus.fall_en = 16'h0000;
        bus.rise_en = 16'h0001;
        bus.pin_in  = 16'h0001;
        step(2);
        // Here the rise is visible and coincides with the clear on the next edge.
        bus.clr_wr   = 1'b1;
        bus.clr_mask = 16'h0001;
        step(1);
        bus.clr_wr   = 1'b0;
        chk("set_wins", {16'h0, bus.irq_pending}, 32'h0001);
        bus.clr_wr   = 1'b1;
        step(1);
        bus.clr_wr   = 1'b0;
        chk("clr_again", {16'h0, bus.irq_pending}, 32'h0);

        // Enabling after an edge does not latch it retroactively.
        bus.rise_en = 16'h0000;
        bus.pin_in  = 16'h0003;
        step(4);
        bus.rise_en = 16'h0002;
        step(2);
        chk("no_retro", {16'h0, bus.irq_pending}, 32'h0);

        // Falling-only enable on bit 15.
        bus.rise_en = 16'h0000;
        bus.fall_en = 16'h8000;
        bus.pin_in  = 16'h8000;
        step(4);
        chk("b15_rise_none", {16'h0, bus.irq_pending}, 32'h0);
        bus.pin_in  = 16'h0000;
        step(2);
        chk("b15_fall_e2", {16'h0, bus.irq_pending}, 32'h0);
        step(1);
        chk("b15_fall_e3", {16'h0, bus.irq_pending}, 32'h8000);
        bus.fall_en  = 16'h0000;
        bus.clr_wr   = 1'b1;
        bus.clr_mask = 16'hFFFF;
        step(1);
        bus.clr_wr   = 1'b0;
        step(2);

        // All 16 bits rise together, then a partial clear.
        bus.rise_en = 16'hFFFF;
        bus.pin_in  = 16'hFFFF;
        step(2);
        chk("all_rise_e2", {16'h0, bus.irq_pending}, 32'h0);
        step(1);
        chk("all_rise_e3", {16'h0, bus.irq_pending}, 32'hFFFF);
        bus.clr_wr   = 1'b1;
        bus.clr_mask = 16'h5555;
        step(1);
        bus.clr_wr   = 1'b0;
        chk("part_clr", {16'h0, bus.irq_pending}, 32'hAAAA);
        chk("part_irq", {31'h0, bus.irq}, 32'h1);

        // Build up 16'h00F0 for the asynchronous reset check.
        bus.rise_en  = 16'h0000;
        bus.pin_in   = 16'h0000;
        bus.clr_wr   = 1'b1;
        bus.clr_mask = 16'hFFFF;
        step(1);
        bus.clr_wr   = 1'b0;
        step(3);
        bus.rise_en  = 16'h00F0;
        bus.pin_in   = 16'h00F0;
        step(3);
        chk("pre_rst", {16'h0, bus.irq_pending}, 32'h00F0);
`else
        // Debounced build: a 5-cycle glitch on bit 3 must be filtered.
        begin
            logic seen;
            int   n;
            bus.rise_en = 16'hFFFF;
            bus.fall_en = 16'hFFFF;
            seen        = 1'b0;
            bus.pin_in  = 16'h0008;
            for (int i = 0; i < 5; i++) begin
                step(1);
                seen = seen | bus.pin_clean[3] | bus.irq_pending[3];
            end
            bus.pin_in = 16'h0000;
            for (int i = 0; i < 30; i++) begin
                step(1);
                seen = seen | bus.pin_clean[3] | bus.irq_pending[3];
            end
            chk("glitch_filt", {31'h0, seen}, 32'h0);
            chk("glitch_pend", {16'h0, bus.irq_pending}, 32'h0);

            // A held level is accepted within 2+12+1 cycles.
            bus.pin_in = 16'h0008;
            n = 0;
            while (!bus.pin_clean[3] && n < 20) begin
                step(1);
                n++;
            end
            chk("db_lat_ok", {31'h0, (n <= 15)}, 32'h1);
            chk("db_clean", {16'h0, bus.pin_clean}, 32'h0008);
            step(1);
            chk("db_pend", {16'h0, bus.irq_pending}, 32'h0008);
            step(5);
        end
`endif

        // Asynchronous reset in the middle of a cycle clears everything at once.
        #3;
        rst = 1'b0;
        #1;
        chk("arst_clean", {16'h0, bus.pin_clean}, 32'h0);
        chk("arst_pend",  {16'h0, bus.irq_pending}, 32'h0);
        chk("arst_irq",   {31'h0, bus.irq}, 32'h0);
        bus.pin_in  = 16'h0000;
        bus.rise_en = 16'hFFFF;
        bus.fall_en = 16'hFFFF;
        @(posedge clk);
        #1;
        rst = 1'b1;
        step(60);
        chk("post_rst_pend", {16'h0, bus.irq_pending}, 32'h0);
        chk("post_rst_irq",  {31'h0, bus.irq}, 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
